// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcode encodings and
// the parameter sanity rule used at elaboration time.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // WIDTH must split into whole CHUNK-bit slices, at least one of them.
  function automatic bit chunking_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice. c_msb is the carry entering the
// slice's top bit, which the most significant slice needs for signed overflow.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c_s;

  // ripple carry chain across the slice
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]       = a[i] ^ b[i] ^ c_s[i];
      c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c_s[CHUNK];
  assign c_msb = c_s[CHUNK-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage with
// operand skew, sum de-skew, a valid chain and a whole-pipeline stall.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSTAGE = WIDTH / CHUNK;

  if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic              advance_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic              cin_eff_s;
  logic [NSTAGE:0]   valid_r;
  logic [NSTAGE:0]   carry_r;
  logic [NSTAGE-1:0] co_s;
  logic              msb_top_s;
  logic              ovf_r;

  // Subtraction is folded into the operands here so no op bit travels down the pipe.
  assign b_eff_s   = (op == OP_SUB) ? ~B : B;
  assign cin_eff_s = (op == OP_SUB) ? ~cin : cin;

  assign advance_s = !valid_r[NSTAGE] || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = valid_r[NSTAGE];
  assign cout      = carry_r[NSTAGE];
  assign overflow  = ovf_r;

  // valid chain, inter-stage carries and the overflow flag of the top slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      carry_r <= '0;
      ovf_r   <= 1'b0;
    end else if (advance_s) begin
      valid_r <= {valid_r[NSTAGE-1:0], in_valid};
      carry_r <= {co_s, cin_eff_s};
      ovf_r   <= msb_top_s ^ co_s[NSTAGE-1];
    end
  end

  for (genvar j = 0; j < NSTAGE; j++) begin : g_slice
    // a_sk/b_sk[0] is the entry register; slice j consumes its operands j edges later.
    logic [CHUNK-1:0] a_sk [0:j];
    logic [CHUNK-1:0] b_sk [0:j];
    logic [CHUNK-1:0] s_dk [j+1:NSTAGE];
    logic [CHUNK-1:0] s_s;

    if (j == NSTAGE - 1) begin : g_top
      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_sk[j]),
        .b     (b_sk[j]),
        .ci    (carry_r[j]),
        .s     (s_s),
        .co    (co_s[j]),
        .c_msb (msb_top_s)
      );
    end else begin : g_low
      logic unused_msb_s;
      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_sk[j]),
        .b     (b_sk[j]),
        .ci    (carry_r[j]),
        .s     (s_s),
        .co    (co_s[j]),
        .c_msb (unused_msb_s)
      );
    end

    // operand skew ahead of the slice, sum de-skew behind it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= j; k++) begin
          a_sk[k] <= '0;
          b_sk[k] <= '0;
        end
        for (int k = j + 1; k <= NSTAGE; k++) begin
          s_dk[k] <= '0;
        end
      end else if (advance_s) begin
        a_sk[0] <= A[j*CHUNK +: CHUNK];
        b_sk[0] <= b_eff_s[j*CHUNK +: CHUNK];
        for (int k = 1; k <= j; k++) begin
          a_sk[k] <= a_sk[k-1];
          b_sk[k] <= b_sk[k-1];
        end
        s_dk[j+1] <= s_s;
        for (int k = j + 2; k <= NSTAGE; k++) begin
          s_dk[k] <= s_dk[k-1];
        end
      end
    end

    assign Sum[j*CHUNK +: CHUNK] = s_dk[NSTAGE];
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=32, CHUNK=8): directed vectors,
// stall/bubble patterns, random traffic and mid-flight reset against a latency model.
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int NSTAGE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum;
  logic        cout;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: in-flight results {cout, overflow, sum} with edges advanced since acceptance
  logic [33:0] exp_q[$];
  int          age_q[$];

  logic [31:0] dir_a [6] = '{32'h0000_00FF, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                             32'h0000_0005, 32'h8000_0000, 32'h0000_000A};
  logic [31:0] dir_b [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000,
                             32'h0000_0007, 32'h0000_0001, 32'h0000_0003};
  logic        dir_c [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        dir_o [6] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
  logic [33:0] dir_e [6] = '{{1'b0, 1'b0, 32'h0000_0100}, {1'b0, 1'b1, 32'h8000_0000},
                             {1'b1, 1'b0, 32'h0000_0000}, {1'b0, 1'b0, 32'hFFFF_FFFE},
                             {1'b1, 1'b1, 32'h7FFF_FFFF}, {1'b1, 1'b0, 32'h0000_0006}};

  adder_pipe #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: exact integer results, then wrap / range tests.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic o);
    longint unsigned ua, ub, uc, r;
    longint sa, sb, sc, s;
    longint lim;
    logic [31:0] sum;
    logic co, ov;
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    uc  = {63'h0, c};
    sa  = $signed(a);
    sb  = $signed(b);
    sc  = {63'h0, c};
    lim = 64'sd2147483647;
    if (o == OP_ADD) begin
      r   = ua + ub + uc;
      sum = a + b + {31'h0, c};
      co  = (r >= 64'h1_0000_0000);
      s   = sa + sb + sc;
    end else begin
      sum = a - b - {31'h0, c};
      co  = (ua >= ub + uc);
      s   = sa - sb - sc;
    end
    ov = (s > lim) || (s < -lim - 64'sd1);
    return {co, ov, sum};
  endfunction

  function automatic bit model_valid();
    return (age_q.size() > 0) && (age_q[0] == NSTAGE);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic o, input logic r);
    in_valid  = v;
    A         = a;
    B         = b;
    cin       = c;
    op        = o;
    out_ready = r;
  endtask

  // one clock edge applied to the model, ending on the following falling edge
  task automatic tick();
    bit mv, adv;
    mv  = model_valid();
    adv = !mv || out_ready;
    @(posedge clk);
    if (adv) begin
      if (mv) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i] = age_q[i] + 1;
      if (in_valid) begin
        exp_q.push_back(ref_op(A, B, cin, op));
        age_q.push_back(0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b0);
    #2;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else n_pass++;
    n_checks++;
    if (Sum !== 32'h0) $display("FAIL reset_sum got=%h want=00000000", Sum);
    else n_pass++;
    n_checks++;
    if ({cout, overflow} !== 2'b00) $display("FAIL reset_flags got=%b%b want=00", cout, overflow);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else n_pass++;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int first_cyc = -1;
    int n_out = 0;
    for (int cyc = 0; cyc < 6 + NSTAGE + 4; cyc++) begin
      if (cyc < 6) drive(1'b1, dir_a[cyc], dir_b[cyc], dir_c[cyc], dir_o[cyc], 1'b1);
      else         drive(1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
      tick();
      n_checks++;
      if (out_valid !== model_valid()) $display("FAIL dir_valid cyc=%0d got=%b want=%b", cyc, out_valid, model_valid());
      else n_pass++;
      if (out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        n_checks++;
        if (n_out < 6 && {cout, overflow, Sum} === dir_e[n_out]) n_pass++;
        else $display("FAIL dir_result idx=%0d got=%b/%b/%h", n_out, cout, overflow, Sum);
        n_out++;
      end
    end
    n_checks++;
    if (first_cyc != NSTAGE) $display("FAIL dir_latency got=%0d want=%0d", first_cyc, NSTAGE);
    else n_pass++;
    n_checks++;
    if (n_out != 6) $display("FAIL dir_count got=%0d want=6", n_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    logic [31:0] got[$];
    bit er;
    for (int cyc = 0; cyc < 80 && got.size() < 8; cyc++) begin
      drive(issued < 8, 32'(issued + 1), 32'(issued + 1), 1'b0, OP_ADD, (cyc % 2) == 0);
      #1;
      er = !model_valid() || out_ready;
      n_checks++;
      if (in_ready !== er) $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, er);
      else n_pass++;
      if (out_valid === 1'b1 && out_ready) got.push_back(Sum);
      if (in_valid && er) issued++;
      tick();
      n_checks++;
      if (out_valid !== model_valid()) $display("FAIL b2b_valid cyc=%0d got=%b want=%b", cyc, out_valid, model_valid());
      else n_pass++;
      if (model_valid()) begin
        n_checks++;
        if ({cout, overflow, Sum} !== exp_q[0]) $display("FAIL b2b_hold cyc=%0d got=%h want=%h", cyc, Sum, exp_q[0][31:0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (got.size() != 8) $display("FAIL b2b_count got=%0d want=8", got.size());
    else n_pass++;
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== 32'(2 * (i + 1))) $display("FAIL b2b_order idx=%0d got=%0d want=%0d", i, got[i], 2 * (i + 1));
      else n_pass++;
    end
  endtask

  task automatic test_bubbles();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic obs [10];
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 5) drive(pat[cyc], $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      else         drive(1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
      tick();
      obs[cyc] = out_valid;
      if (model_valid()) begin
        n_checks++;
        if ({cout, overflow, Sum} !== exp_q[0]) $display("FAIL bub_result cyc=%0d got=%h want=%h", cyc, Sum, exp_q[0][31:0]);
        else n_pass++;
      end
    end
    for (int c = 0; c < NSTAGE; c++) begin
      n_checks++;
      if (obs[c] !== 1'b0) $display("FAIL bub_early cyc=%0d got=%b want=0", c, obs[c]);
      else n_pass++;
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (obs[c + NSTAGE] !== pat[c]) $display("FAIL bub_pattern slot=%0d got=%b want=%b", c, obs[c + NSTAGE], pat[c]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 360) drive($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
      else           drive(1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
      #1;
      er = !model_valid() || out_ready;
      n_checks++;
      if (in_ready !== er) $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, er);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== model_valid()) $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, out_valid, model_valid());
      else n_pass++;
      if (model_valid()) begin
        n_checks++;
        if ({cout, overflow, Sum} !== exp_q[0])
          $display("FAIL rnd_result cyc=%0d got=%b/%b/%h want=%b/%b/%h", cyc, cout, overflow, Sum,
                   exp_q[0][33], exp_q[0][32], exp_q[0][31:0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rnd_drain got=%0d want=0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_flush();
    int n_seen = 0;
    int seen_cyc = -1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive(1'b1, $urandom(), $urandom(), 1'b0, OP_ADD, 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || Sum !== 32'h0 || cout !== 1'b0 || overflow !== 1'b0)
      $display("FAIL flush_clear got=%b/%h/%b/%b want=0/00000000/0/0", out_valid, Sum, cout, overflow);
    else n_pass++;
    exp_q.delete();
    age_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 0) drive(1'b1, 32'h1234_5678, 32'h0000_1111, 1'b1, OP_SUB, 1'b1);
      else          drive(1'b0, 32'h0, 32'h0, 1'b0, OP_ADD, 1'b1);
      tick();
      if (out_valid === 1'b1) begin
        n_seen++;
        if (seen_cyc < 0) seen_cyc = cyc;
        n_checks++;
        if ({cout, overflow, Sum} !== {1'b1, 1'b0, 32'h1234_4566})
          $display("FAIL flush_new got=%b/%b/%h want=1/0/12344566", cout, overflow, Sum);
        else n_pass++;
      end
    end
    n_checks++;
    if (n_seen != 1 || seen_cyc != NSTAGE)
      $display("FAIL flush_after got=%0d results at cyc %0d want=1 at cyc %0d", n_seen, seen_cyc, NSTAGE);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_bubbles();
    test_random();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the fixed 8-bit combinational adder. The WIDTH-bit operation is split into CHUNK-bit ripple slices, one register stage per slice. A valid/ready handshake with full-pipeline stall sits on the streaming side. It sits in the datapath wherever a wide add/sub must close timing at clock rate and accept one operation per cycle.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK, ≥ CHUNK.
- CHUNK, 8, bits added per pipeline stage; NSTAGE = WIDTH/CHUNK is the latency.
- clk  in  1  sole clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  pipeline accepts operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result this cycle.
- Sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  out  1  signed overflow.

## Operation
- add: Sum = A + B + cin. sub: Sum = A − B − cin, implemented as A + ~B + !cin. Sum wraps modulo 2^WIDTH.
- cout = carry out of bit WIDTH−1 of the internal addition. overflow = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Stage k (0..NSTAGE−1) adds chunk k of A and effective B, plus the carry registered from stage k−1. Stage 0 uses the effective cin.
- Upper operand chunks travel through skew registers so they reach their stage aligned with the carry. Completed lower sum chunks travel through de-skew registers so all chunks exit together.
- op is resolved at entry: B inversion and cin inversion are done before stage-0 registers. No op bit propagates.
- Each stage carries a valid bit. Bubbles (in_valid=0 while advancing) propagate as invalid slots.
- Stall rule: advance = !out_valid || out_ready. in_ready = advance. When advance = 0, every stage register holds, including skew, de-skew and valid bits.
- A transfer occurs on in_valid && in_ready. Output is consumed on out_valid && out_ready.
- Results leave strictly in issue order. Nothing is dropped or duplicated under any stall pattern.

## Timing
- Latency: an operation accepted at edge n appears with out_valid=1 after edge n+NSTAGE, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one operation per cycle while out_ready=1.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid, A or B to any output.
- Sum, cout, overflow and out_valid are registered, and are stable while out_valid && !out_ready.
- Reset: asserting rst immediately clears all valid bits and all data, skew and carry registers to 0. Outputs are then out_valid=0, Sum=0, cout=0, overflow=0, and in_ready=1.
- Reset mid-operation flushes in-flight operations. None appears after rst deasserts.
- The first acceptance is possible on the first rising edge after deassertion.
- Simultaneous accept and emit in the same cycle is legal and is the steady-state case.
- NSTAGE=1 degenerates to a single registered adder with latency 1.

## Structure
- Shared package adder_pkg holds:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - A compile-time check that WIDTH % CHUNK == 0; an elaboration error is raised otherwise.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder with inputs a, b, ci and outputs s, co, c_msb (carry into its MSB, used only by the top slice for overflow). Instantiate it NSTAGE times via generate.
- adder_pipe contains only the registers, skew/de-skew arrays, valid chain and stall logic.

## Test plan
All cases use WIDTH=32, CHUNK=8, so latency is 4.
- add 0x0000_00FF + 0x0000_0001, cin=0, out_ready=1 → 4 cycles later Sum=0x0000_0100, cout=0, overflow=0 (carry crosses the chunk boundary).
- add 0x7FFF_FFFF + 0x0000_0001 → Sum=0x8000_0000, overflow=1, cout=0. Then add 0xFFFF_FFFF + 0, cin=1 → Sum=0x0000_0000, cout=1, overflow=0.
- sub 5 − 7, cin=0 → Sum=0xFFFF_FFFE, cout=0, overflow=0. Then sub 0x8000_0000 − 1 → Sum=0x7FFF_FFFF, cout=1, overflow=1. Then sub 10 − 3 with cin=1 → Sum=6.
- Issue 8 back-to-back adds (i + i for i=1..8) with out_ready toggling 1,0,1,0… → results 2,4,…,16 in order, none lost. in_ready=0 exactly when out_valid && !out_ready. Outputs hold during the stall.
- Mixed bubbles: in_valid pattern 1,0,1,1,0 → out_valid pattern identical, shifted by 4 cycles.
- Assert rst for one cycle while 3 operations are in flight, asynchronously between edges → out_valid drops to 0 immediately. No result from those operations appears afterwards. A new operation issued after release emerges 4 cycles later with the correct value.
